// File: rtl/ribm_key_equation_solver.sv
// Reformulated inversionless Berlekamp-Massey (riBM) key-equation solver for
// RS(544,522) over GF(2^10), t = 11. One riBM iteration per clock across a
// 3T+1 processing-element array (T+1 lambda PEs, 2T delta PEs, two GF
// multipliers each).
//
// Ports:
//   clk_i           clock
//   rst_i           asynchronous active-high reset
//   syn_i           syndromes, syn_i[j] = S_j for j = 1..2T (syn_i[0] unused)
//   syn_valid_i     syndromes valid, qualifies start_i
//   start_i         one-cycle start pulse
//   busy_o          iterations in progress
//   done_o          one-cycle completion pulse
//   sigma_bus_o     error-locator lambda[0..T], index = power of x
//   v_bus_o         final delta[0..T-1] (error-evaluator coefficients)
//   omega_bus_o     same contents as v_bus_o
//   result_valid_o  output buses hold a completed result

// Combinational GF(2^W) polynomial-basis multiplier.
//   a, b  operands
//   p     a*b reduced by the field polynomial (Poly holds its low W bits)
module gf_mul #(
  parameter int unsigned W    = 10,
  parameter logic [W-1:0] Poly = W'(9)
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);
  // MSB-first shift-and-add with reduction folded into each shift.
  always_comb begin
    p = '0;
    for (int i = W - 1; i >= 0; i--) begin
      p = {p[W-2:0], 1'b0} ^ (p[W-1] ? Poly : '0);
      if (b[i]) p = p ^ a;
    end
  end
endmodule

module ribm_key_equation_solver #(
  parameter int unsigned T = 11,
  parameter int unsigned W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] syn_i [0:2*T],
  input  logic         syn_valid_i,
  input  logic         start_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] sigma_bus_o [0:T],
  output logic [W-1:0] v_bus_o [0:T-1],
  output logic [W-1:0] omega_bus_o [0:T-1],
  output logic         result_valid_o
);
  localparam int unsigned N  = 2 * T;
  localparam int unsigned RW = $clog2(N);
  localparam int unsigned KW = 6;

  logic [W-1:0]        lambda_q [0:T];
  logic [W-1:0]        b_q      [0:T];
  logic [W-1:0]        delta_q  [0:N-1];
  logic [W-1:0]        theta_q  [0:N-1];
  logic [W-1:0]        gamma_q;
  logic signed [KW-1:0] k_q;
  logic [RW-1:0]       r_q;
  logic                busy_q, done_q, valid_q;
  logic [W-1:0]        sigma_q  [0:T];
  logic [W-1:0]        v_q      [0:T-1];

  logic [W-1:0] lambda_nx [0:T];
  logic [W-1:0] delta_nx  [0:N-1];
  logic [W-1:0] delta_up  [0:N-1];  // delta shifted down one place, zero-filled
  logic [W-1:0] d0;
  logic         swap;
  logic         last;

  logic unused_syn0;
  assign unused_syn0 = ^syn_i[0];

  assign d0   = delta_q[0];
  // Discrepancy nonzero and k >= 0: current lambda/delta become the new b/theta.
  assign swap = (d0 != '0) && !k_q[KW-1];
  assign last = (r_q == RW'(N - 1));

  for (genvar i = 0; i <= T; i++) begin : g_lam_pe
    logic [W-1:0] b_prev, p_g, p_d;
    if (i == 0) begin : g_first
      assign b_prev = '0;
    end else begin : g_rest
      assign b_prev = b_q[i-1];
    end
    gf_mul #(.W(W)) u_mul_g (.a(gamma_q), .b(lambda_q[i]), .p(p_g));
    gf_mul #(.W(W)) u_mul_d (.a(d0),      .b(b_prev),      .p(p_d));
    assign lambda_nx[i] = p_g ^ p_d;
  end

  for (genvar i = 0; i < N; i++) begin : g_del_pe
    logic [W-1:0] p_g, p_d;
    if (i == N - 1) begin : g_top
      assign delta_up[i] = '0;
    end else begin : g_mid
      assign delta_up[i] = delta_q[i+1];
    end
    gf_mul #(.W(W)) u_mul_g (.a(gamma_q), .b(delta_up[i]), .p(p_g));
    gf_mul #(.W(W)) u_mul_d (.a(d0),      .b(theta_q[i]),  .p(p_d));
    assign delta_nx[i] = p_g ^ p_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i <= T; i++) begin
        lambda_q[i] <= '0;
        b_q[i]      <= '0;
        sigma_q[i]  <= '0;
      end
      for (int i = 0; i < N; i++) begin
        delta_q[i] <= '0;
        theta_q[i] <= '0;
      end
      for (int i = 0; i < T; i++) v_q[i] <= '0;
      gamma_q <= '0;
      k_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (start_i && syn_valid_i) begin
          for (int i = 0; i <= T; i++) begin
            lambda_q[i] <= (i == 0) ? W'(1) : '0;
            b_q[i]      <= (i == 0) ? W'(1) : '0;
          end
          for (int i = 0; i < N; i++) begin
            delta_q[i] <= syn_i[i+1];
            theta_q[i] <= syn_i[i+1];
          end
          gamma_q <= W'(1);
          k_q     <= '0;
          r_q     <= '0;
          busy_q  <= 1'b1;
          valid_q <= 1'b0;
        end
      end else begin
        lambda_q <= lambda_nx;
        delta_q  <= delta_nx;
        if (swap) begin
          b_q     <= lambda_q;
          theta_q <= delta_up;
          gamma_q <= d0;
          k_q     <= -k_q - KW'(1);
        end else begin
          b_q[0] <= '0;
          for (int i = 1; i <= T; i++) b_q[i] <= b_q[i-1];
          k_q <= k_q + KW'(1);
        end
        r_q <= r_q + RW'(1);
        if (last) begin
          sigma_q <= lambda_nx;
          for (int i = 0; i < T; i++) v_q[i] <= delta_nx[i];
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign result_valid_o = valid_q;
  assign sigma_bus_o    = sigma_q;
  assign v_bus_o        = v_q;
  assign omega_bus_o    = v_q;
endmodule

// File: tb/tb_ribm_key_equation_solver.sv
module tb_ribm_key_equation_solver;
  localparam int T = 11;
  localparam int W = 10;
  localparam int N = 2 * T;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] syn [0:N];
  logic         syn_valid, start;
  logic         busy, done, rv;
  logic [W-1:0] sig_o [0:T];
  logic [W-1:0] v_o   [0:T-1];
  logic [W-1:0] om_o  [0:T-1];

  ribm_key_equation_solver #(.T(T), .W(W)) dut (
    .clk_i(clk), .rst_i(rst), .syn_i(syn), .syn_valid_i(syn_valid), .start_i(start),
    .busy_o(busy), .done_o(done), .sigma_bus_o(sig_o), .v_bus_o(v_o),
    .omega_bus_o(om_o), .result_valid_o(rv)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_t [0:1022];
  int log_t [0:1023];
  int exp_sig [0:T];
  int exp_v [0:T-1];
  int pos_q [$];

  // GF(2^10) multiply through log/antilog tables of alpha = x.
  function automatic int gmul(int a, int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 1023];
  endfunction

  function automatic int apow(int e);
    return exp_t[((e % 1023) + 1023) % 1023];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference riBM over the current syndromes, 2T iterations.
  function automatic void ribm();
    int lam [0:T], bb [0:T], nl [0:T];
    int del [0:N-1], th [0:N-1], nd [0:N-1];
    int gam, kk, d0, up;
    for (int i = 0; i <= T; i++) begin lam[i] = (i == 0); bb[i] = (i == 0); end
    for (int i = 0; i < N; i++) begin del[i] = int'(syn[i+1]); th[i] = del[i]; end
    gam = 1; kk = 0;
    for (int it = 0; it < N; it++) begin
      d0 = del[0];
      for (int i = 0; i <= T; i++)
        nl[i] = gmul(gam, lam[i]) ^ ((i > 0) ? gmul(d0, bb[i-1]) : 0);
      for (int i = 0; i < N; i++) begin
        up = (i < N - 1) ? del[i+1] : 0;
        nd[i] = gmul(gam, up) ^ gmul(d0, th[i]);
      end
      if (d0 != 0 && kk >= 0) begin
        bb = lam;
        for (int i = 0; i < N; i++) th[i] = (i < N - 1) ? del[i+1] : 0;
        gam = d0;
        kk = -kk - 1;
      end else begin
        for (int i = T; i > 0; i--) bb[i] = bb[i-1];
        bb[0] = 0;
        kk++;
      end
      lam = nl;
      del = nd;
    end
    for (int i = 0; i <= T; i++) exp_sig[i] = lam[i];
    for (int i = 0; i < T; i++) exp_v[i] = del[i];
  endfunction

  // Random error pattern with nerr distinct positions; S_j = sum e * X^j.
  task automatic make_syn(input int nerr);
    int p, e, dup;
    int s [1:N];
    pos_q.delete();
    for (int j = 1; j <= N; j++) s[j] = 0;
    while (pos_q.size() < nerr) begin
      p = int'($urandom_range(543, 0));
      dup = 0;
      foreach (pos_q[q]) if (pos_q[q] == p) dup = 1;
      if (dup == 0) begin
        pos_q.push_back(p);
        e = int'($urandom_range(1023, 1));
        for (int j = 1; j <= N; j++) s[j] ^= gmul(e, apow(p * j));
      end
    end
    syn[0] = W'($urandom);
    for (int j = 1; j <= N; j++) syn[j] = W'(s[j]);
  endtask

  task automatic start_frame();
    ribm();
    syn_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic check_result(input string tag);
    for (int i = 0; i <= T; i++) chk($sformatf("%s_sigma%0d", tag, i), sig_o[i], exp_sig[i]);
    for (int i = 0; i < T; i++) begin
      chk($sformatf("%s_v%0d", tag, i), v_o[i], exp_v[i]);
      chk($sformatf("%s_omega%0d", tag, i), om_o[i], exp_v[i]);
    end
  endtask

  // Locator must vanish at X^-1 for every error position.
  task automatic check_roots(input string tag);
    int ev;
    foreach (pos_q[q]) begin
      ev = 0;
      for (int i = 0; i <= T; i++) ev ^= gmul(int'(sig_o[i]), apow(-(pos_q[q] * i)));
      chk($sformatf("%s_root%0d", tag, pos_q[q]), ev, 0);
    end
  endtask

  task automatic run_frame(input string tag);
    int n;
    start_frame();
    wait_done(n);
    chk({tag, "_latency"}, n, 22);
    chk({tag, "_valid"}, rv, 1);
    check_result(tag);
  endtask

  initial begin
    int x, n;
    x = 1;
    for (int i = 0; i < 1023; i++) begin
      exp_t[i] = x;
      log_t[x] = i;
      x = x << 1;
      if ((x & 1024) != 0) x = x ^ 'h409;
    end
    log_t[0] = 0;

    rst = 1'b1; start = 1'b0; syn_valid = 1'b0;
    for (int j = 0; j <= N; j++) syn[j] = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", rv, 0);
    chk("rst_sigma0", sig_o[0], 0);
    chk("rst_v0", v_o[0], 0);
    rst = 1'b0;
    @(negedge clk);

    // All-zero syndromes.
    run_frame("zero");
    chk("zero_sigma0_const", sig_o[0], 1);
    @(negedge clk);
    chk("zero_done_drop", done, 0);
    chk("zero_valid_hold", rv, 1);
    chk("zero_busy_idle", busy, 0);

    // Single error of value 1 at position 0.
    for (int j = 1; j <= N; j++) syn[j] = W'(1);
    pos_q.delete();
    pos_q.push_back(0);
    run_frame("ones");
    chk("ones_sigma1_const", sig_o[1], 1);
    chk("ones_v0_const", v_o[0], 1);
    check_roots("ones");
    @(negedge clk);

    // 1..12 random errors, two variants each.
    for (int ne = 1; ne <= 12; ne++) begin
      for (int var_i = 1; var_i <= 2; var_i++) begin
        make_syn(ne);
        run_frame($sformatf("e%0dv%0d", ne, var_i));
        if (ne <= T) check_roots($sformatf("e%0dv%0d", ne, var_i));
        @(negedge clk);
      end
    end

    // Back-to-back: second start driven during the done cycle.
    make_syn(4);
    start_frame();
    wait_done(n);
    check_result("b2b_a");
    make_syn(6);
    start_frame();
    chk("b2b_busy", busy, 1);
    chk("b2b_done_clr", done, 0);
    chk("b2b_valid_clr", rv, 0);
    wait_done(n);
    chk("b2b_latency", n, 22);
    check_result("b2b_b");
    check_roots("b2b_b");
    @(negedge clk);

    // start while busy is ignored, even with different syndromes on the bus.
    make_syn(7);
    start_frame();
    repeat (4) @(negedge clk);
    for (int j = 1; j <= N; j++) syn[j] = W'($urandom);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check_result("busy_start");
    check_roots("busy_start");
    @(negedge clk);

    // start with syn_valid low is ignored.
    syn_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("novalid_busy", busy, 0);
    chk("novalid_rv", rv, 1);
    chk("novalid_done", done, 0);
    check_result("novalid_hold");
    syn_valid = 1'b1;

    // Reset at iteration 10 aborts; the next frame starts cleanly.
    make_syn(9);
    start_frame();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_valid", rv, 0);
    for (int i = 0; i <= T; i++) chk($sformatf("abort_sigma%0d", i), sig_o[i], 0);
    for (int i = 0; i < T; i++) chk($sformatf("abort_v%0d", i), v_o[i], 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    make_syn(5);
    run_frame("post_rst");
    check_roots("post_rst");
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
